// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions: default widths, reset PC and fetch FSM state encodings.
package cpu_defs;

    localparam int              DEFAULT_ADDR_W   = 16;
    localparam int              DEFAULT_DATA_W   = 16;
    localparam logic [15:0]     DEFAULT_RESET_PC = 16'h0000;

    // 2'd3 is unused; the fetch FSM recovers from it by returning to IDLE.
    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc_register.sv
// Program counter register with async reset; load takes priority over increment.
module pc_register #(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    // Increment wraps naturally modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: req/ack memory fetch, valid/ready delivery to decode, redirect/squash.
module fetch_ctrl
    import cpu_defs::*;
#(
    parameter int                ADDR_W   = cpu_defs::DEFAULT_ADDR_W,
    parameter int                DATA_W   = cpu_defs::DEFAULT_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(cpu_defs::DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ins_valid,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              ins_ready,
    output logic [ADDR_W-1:0] pc_out
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic              squash;
    logic              squash_next;
    logic              capture;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (target_addr),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH_IDLE;
            squash <= 1'b0;
        end else begin
            state  <= state_next;
            squash <= squash_next;
        end
    end

    // The PC already holds the latest redirect target, so a squashed ack just re-requests it.
    always_comb begin
        state_next  = state;
        squash_next = squash;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        capture     = 1'b0;
        case (state)
            FETCH_IDLE: begin
                state_next = FETCH_REQ;
                pc_load    = redirect;
            end
            FETCH_REQ: begin
                if (mem_ack) begin
                    if (squash || redirect) begin
                        pc_load     = redirect;
                        squash_next = 1'b0;
                    end else begin
                        capture    = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = FETCH_HOLD;
                    end
                end else if (redirect) begin
                    pc_load     = 1'b1;
                    squash_next = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (redirect) begin
                    pc_load    = 1'b1;
                    state_next = FETCH_REQ;
                end else if (ins_ready) begin
                    state_next = FETCH_REQ;
                end
            end
            default: begin
                state_next  = FETCH_IDLE;
                squash_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_data <= '0;
            ins_pc   <= '0;
        end else if (capture) begin
            ins_data <= mem_rdata;
            ins_pc   <= pc;
        end
    end

    assign mem_req   = (state == FETCH_REQ);
    assign ins_valid = (state == FETCH_HOLD);
    assign mem_addr  = pc;
    assign pc_out    = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal expectations plus random traffic against a model.
module tb_fetch_ctrl;

    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] target_addr = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        ins_ready = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        ins_valid;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic [15:0] pc_out;

    int checks_total  = 0;
    int checks_passed = 0;
    int dut_delivered = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .target_addr (target_addr),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ins_valid   (ins_valid),
        .ins_data    (ins_data),
        .ins_pc      (ins_pc),
        .ins_ready   (ins_ready),
        .pc_out      (pc_out)
    );

    always #5 clk = ~clk;

    // Model: "started" = left reset, "holding" = a fetched word awaits decode,
    // "squash" = the outstanding memory reply belongs to an abandoned address.
    logic        m_started;
    logic        m_holding;
    logic        m_squash;
    logic [15:0] m_pc;
    logic [15:0] m_data;
    logic [15:0] m_ipc;
    int          m_delivered = 0;
    wire         m_req = m_started && !m_holding;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_holding <= 1'b0;
            m_squash  <= 1'b0;
            m_pc      <= 16'h0000;
            m_data    <= 16'h0000;
            m_ipc     <= 16'h0000;
        end else if (!m_started) begin
            m_started <= 1'b1;
            if (redirect) m_pc <= target_addr;
        end else if (!m_holding) begin
            if (mem_ack) begin
                if (m_squash || redirect) begin
                    m_squash <= 1'b0;
                    if (redirect) m_pc <= target_addr;
                end else begin
                    m_data    <= mem_rdata;
                    m_ipc     <= m_pc;
                    m_pc      <= m_pc + 16'd1;
                    m_holding <= 1'b1;
                end
            end else if (redirect) begin
                m_pc     <= target_addr;
                m_squash <= 1'b1;
            end
        end else begin
            if (ins_ready) m_delivered <= m_delivered + 1;
            if (redirect) begin
                m_pc      <= target_addr;
                m_holding <= 1'b0;
            end else if (ins_ready) begin
                m_holding <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && ins_valid && ins_ready) dut_delivered <= dut_delivered + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    endtask

    always @(negedge clk) begin
        check("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_pc));
        check("ins_valid", 32'(ins_valid), 32'(m_holding));
        check("ins_data", 32'(ins_data), 32'(m_data));
        check("ins_pc", 32'(ins_pc), 32'(m_ipc));
        check("pc_out", 32'(pc_out), 32'(m_pc));
    end

    task automatic drive(input logic rd, input logic [15:0] tgt, input logic ack,
                         input logic rdy, input logic [15:0] noise);
        redirect    = rd;
        target_addr = tgt;
        mem_ack     = ack;
        ins_ready   = rdy;
        mem_rdata   = m_pc ^ 16'hA5A5 ^ noise;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] addr_seen[$];
        logic [15:0] pc_seen[$];

        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ins_valid", 32'(ins_valid), 32'd0);
        check("rst_ins_data", 32'(ins_data), 32'd0);
        check("rst_ins_pc", 32'(ins_pc), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        rst_n = 1'b1;

        // Single-cycle ack, decode always ready: one instruction every two cycles.
        for (int i = 0; i < 9; i++) begin
            if (mem_req) addr_seen.push_back(mem_addr);
            if (ins_valid) pc_seen.push_back(ins_pc);
            if (i < 8) begin
                drive(1'b0, 16'h0, m_req, 1'b1, 16'h0);
                tick();
            end
        end
        check("t1_fetch_count", 32'(addr_seen.size()), 32'd4);
        check("t1_deliver_count", 32'(pc_seen.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_seen.size()) check("t1_mem_addr", 32'(addr_seen[i]), 32'(i));
            if (i < pc_seen.size()) check("t1_ins_pc", 32'(pc_seen[i]), 32'(i));
        end

        // Decode stalls for five cycles while a word is held.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
            tick();
            check("t2_valid", 32'(ins_valid), 32'd1);
            check("t2_ins_pc", 32'(ins_pc), 32'h0003);
            check("t2_ins_data", 32'(ins_data), 32'hA5A6);
            check("t2_mem_req", 32'(mem_req), 32'd0);
            check("t2_pc_out", 32'(pc_out), 32'h0004);
        end
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0);
        tick();
        check("t2_next_addr", 32'(mem_addr), 32'h0004);

        // Redirect while waiting; the late ack is discarded.
        drive(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("t3_wait_valid", 32'(ins_valid), 32'd0);
            check("t3_wait_req", 32'(mem_req), 32'd1);
            drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
            tick();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h5A5A);
        tick();
        check("t3_dropped_valid", 32'(ins_valid), 32'd0);
        check("t3_refetch_addr", 32'(mem_addr), 32'h0040);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        tick();
        check("t3_ins_pc", 32'(ins_pc), 32'h0040);
        check("t3_ins_data", 32'(ins_data), 32'hA5E5);

        // Redirect and accept in the same HOLD cycle.
        drive(1'b1, 16'h1234, 1'b0, 1'b1, 16'h0);
        tick();
        check("t4_valid_gap", 32'(ins_valid), 32'd0);
        check("t4_mem_addr", 32'(mem_addr), 32'h1234);
        check("t4_dut_delivered", 32'(dut_delivered), 32'd5);
        check("t4_model_delivered", 32'(m_delivered), 32'd5);
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        tick();
        check("t4_ins_pc", 32'(ins_pc), 32'h1234);

        // Wrap from 16'hFFFF to 16'h0000.
        drive(1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0);
        tick();
        check("t5_addr_ffff", 32'(mem_addr), 32'hFFFF);
        drive(1'b0, 16'h0, 1'b1, 1'b1, 16'h0);
        tick();
        check("t5_ins_pc", 32'(ins_pc), 32'hFFFF);
        check("t5_pc_wrap", 32'(pc_out), 32'h0000);
        tick();
        check("t5_req_wrap", 32'(mem_req), 32'd1);
        check("t5_addr_wrap", 32'(mem_addr), 32'h0000);
        tick();
        tick();
        check("t6_pre_addr", 32'(mem_addr), 32'h0001);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(mem_req), 32'd0);
        check("t6_async_valid", 32'(ins_valid), 32'd0);
        check("t6_async_pc", 32'(pc_out), 32'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        check("t6_first_req", 32'(mem_req), 32'd1);
        check("t6_first_addr", 32'(mem_addr), 32'h0000);

        // Random traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 7) == 0,
                  ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                  m_req && ($urandom_range(0, 1) == 1),
                  $urandom_range(0, 1) == 1,
                  16'($urandom));
            tick();
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
